// File: rtl/eth_fifo_wr_sched_pkg.sv
// eth_sched_pkg: shared types and constants for the Ethernet TX FIFO write scheduler.
package eth_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  localparam int ETH_MAX_FRAME_WORDS = 380;
  localparam int ETH_WORD_BYTES      = 4;

  // Next requester index after idx, wrapping at n (n need not be a power of two).
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/eth_fifo_wr_sched_if.sv
// eth_fifo_wr_sched_if: requester handshake, FIFO write port and frame descriptor bundle.
// slave = the scheduler, master = requesters / FIFO / read-side framer.
interface eth_fifo_wr_sched_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 9
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_wr_en;
  logic                          fifo_wr_full;
  logic                          fifo_almost_full;
  logic                          frm_done;
  logic [LEN_WIDTH+1:0]          frm_len_bytes;
  logic [IDX_W-1:0]              frm_src;
  logic                          err_len;

  modport slave (
    input  req, req_len, req_data, req_valid, fifo_wr_full, fifo_almost_full,
    output gnt, req_ready, fifo_wr_data, fifo_wr_en, frm_done, frm_len_bytes, frm_src, err_len
  );

  modport master (
    output req, req_len, req_data, req_valid, fifo_wr_full, fifo_almost_full,
    input  gnt, req_ready, fifo_wr_data, fifo_wr_en, frm_done, frm_len_bytes, frm_src, err_len
  );

endinterface

// File: rtl/eth_fifo_wr_sched_arbiter.sv
// eth_rr_arbiter: combinational request picker, one-hot plus index.
// Macro ETH_SCHED_PRIO_EN: fixed priority (lowest index wins), no pointer input.
// Default: first set request at or after i_ptr, wrapping.
module eth_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
`ifdef ETH_SCHED_PRIO_EN
`else
  input  logic [IDX_W-1:0]   i_ptr,
`endif
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  // Scan requesters in search order and keep the first hit.
  always_comb begin : p_pick
    int j;
    j       = 0;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ETH_SCHED_PRIO_EN
      j = k;
`else
      j = (int'(i_ptr) + k) % NUM_REQ;
`endif
      if (!o_valid && i_req[j]) begin
        o_valid  = 1'b1;
        o_idx    = IDX_W'(j);
        o_gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_fifo_wr_sched.sv
// eth_fifo_wr_sched: frame-atomic scheduler sharing the TX FIFO write port between
// NUM_REQ word sources. Emits a byte-length descriptor on each frame completion.
// Macro ETH_SCHED_PRIO_EN selects fixed priority; default is round-robin.
//
// state | meaning
// IDLE  | waiting for a request while FIFO is not almost full
// ARB   | pick requester, reject bad lengths
// XFER  | stream granted requester's words into the FIFO
// DONE  | one-cycle frame descriptor, advance pointer
module eth_fifo_wr_sched
  import eth_sched_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 9,
  parameter int MAX_WORDS  = ETH_MAX_FRAME_WORDS
) (
  input logic           clk,
  input logic           rst,
  eth_fifo_wr_sched_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_e r_state, w_state_nxt;

  logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic                 r_err_len, w_err_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [LEN_WIDTH-1:0] r_len, w_len_nxt;
  logic [LEN_WIDTH-1:0] r_word_cnt, w_cnt_nxt;

  logic [LEN_WIDTH-1:0]  w_len_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

  logic [NUM_REQ-1:0]   w_arb_gnt;
  logic [IDX_W-1:0]     w_arb_idx;
  logic                 w_arb_valid;
  logic [LEN_WIDTH-1:0] w_arb_len;
  logic                 w_len_bad;
  logic                 w_xfer;
  logic                 w_done;
  logic                 w_accept;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign w_len_arr[g]  = bus.req_len[g*LEN_WIDTH +: LEN_WIDTH];
    assign w_data_arr[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef ETH_SCHED_PRIO_EN
  eth_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req   (bus.req),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );
`else
  logic [IDX_W-1:0] r_rr_ptr, w_rr_nxt;

  eth_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req   (bus.req),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  // Pointer moves past the requester just served, whether it was a frame or a rejection.
  always_comb begin
    w_rr_nxt = r_rr_ptr;
    if (r_state == ARB && w_arb_valid && w_len_bad)
      w_rr_nxt = IDX_W'(wrap_inc(32'(w_arb_idx), NUM_REQ));
    else if (r_state == DONE)
      w_rr_nxt = IDX_W'(wrap_inc(32'(r_idx), NUM_REQ));
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rr_ptr <= '0;
    else     r_rr_ptr <= w_rr_nxt;
  end
`endif

  assign w_arb_len = w_len_arr[w_arb_idx];
  assign w_len_bad = (w_arb_len == '0) || (32'(w_arb_len) > MAX_WORDS);
  assign w_xfer    = (r_state == XFER);
  assign w_done    = (r_state == DONE);

  // Ready only in XFER so the rejection grant pulse can never move data.
  assign bus.req_ready    = w_xfer ? (r_gnt & {NUM_REQ{~bus.fifo_wr_full}}) : '0;
  assign w_accept         = |(bus.req_valid & bus.req_ready);
  assign bus.fifo_wr_en   = w_accept;
  assign bus.fifo_wr_data = w_xfer ? w_data_arr[r_idx] : '0;
  assign bus.gnt          = r_gnt;
  assign bus.err_len      = r_err_len;
  assign bus.frm_done     = w_done;
  assign bus.frm_len_bytes = w_done ? ((LEN_WIDTH+2)'(r_len) << $clog2(ETH_WORD_BYTES)) : '0;
  assign bus.frm_src      = w_done ? r_idx : '0;

  // Next-state and next-register logic for the frame FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = '0;
    w_err_nxt   = 1'b0;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_word_cnt;
    case (r_state)
      IDLE: begin
        if (|bus.req && !bus.fifo_almost_full) w_state_nxt = ARB;
      end
      ARB: begin
        w_state_nxt = IDLE;
        if (w_arb_valid) begin
          w_gnt_nxt = w_arb_gnt;
          if (w_len_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_idx_nxt   = w_arb_idx;
            w_len_nxt   = w_arb_len;
            w_cnt_nxt   = w_arb_len;
            w_state_nxt = XFER;
          end
        end
      end
      XFER: begin
        w_gnt_nxt = r_gnt;
        if (w_accept) begin
          w_cnt_nxt = r_word_cnt - LEN_WIDTH'(1);
          if (r_word_cnt == LEN_WIDTH'(1)) begin
            w_state_nxt = DONE;
            w_gnt_nxt   = '0;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state and frame context registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_err_len  <= 1'b0;
      r_idx      <= '0;
      r_len      <= '0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_err_len  <= w_err_nxt;
      r_idx      <= w_idx_nxt;
      r_len      <= w_len_nxt;
      r_word_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_eth_fifo_wr_sched.sv
// tb_eth_fifo_wr_sched: directed scoreboard bench for eth_fifo_wr_sched (default build).
module tb_eth_fifo_wr_sched;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int LW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_fifo_wr_sched_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  eth_fifo_wr_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_WORDS(380)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          wr_total = 0;
  int          done_total = 0;
  int          want   [NR] = '{0, 0};
  int          served [NR] = '{0, 0};
  logic [LW-1:0] len_q [NR] = '{'0, '0};
  logic [31:0] base   [NR] = '{'0, '0};
  logic [31:0] idx    [NR] = '{'0, '0};

  logic [31:0]   q_data [$];
  logic [31:0]   q_frm  [$];
  logic [NR-1:0] q_err  [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Requester inputs derived from the bench's request bookkeeping.
  always_comb begin
    bus.req       = '0;
    bus.req_len   = '0;
    bus.req_data  = '0;
    bus.req_valid = '1;
    for (int i = 0; i < NR; i++) begin
      bus.req[i]                 = (want[i] != served[i]);
      bus.req_len[i*LW +: LW]    = len_q[i];
      bus.req_data[i*DW +: DW]   = base[i] + idx[i];
    end
  end

  // Requester model: word pointer advances on accept, request retires on done or rejection.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) idx[i] <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) idx[i] <= idx[i] + 1;
        if (bus.frm_done && 32'(bus.frm_src) == i) begin
          idx[i]    <= '0;
          served[i] <= served[i] + 1;
        end
        if (bus.gnt[i] && bus.err_len) served[i] <= served[i] + 1;
      end
    end
  end

  // Output monitor: pops the scoreboard on every write, descriptor and rejection.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (bus.fifo_wr_full) begin
        check("ready_in_full", bus.req_ready, 0);
        check("wr_en_in_full", bus.fifo_wr_en, 0);
      end
      if (bus.fifo_wr_en) begin
        wr_total++;
        check("wr_expected", q_data.size() != 0, 1);
        if (q_data.size() != 0) begin
          e = q_data.pop_front();
          check("wr_data", bus.fifo_wr_data, e);
        end
      end
      if (bus.frm_done) begin
        done_total++;
        check("frm_expected", q_frm.size() != 0, 1);
        if (q_frm.size() != 0) begin
          e = q_frm.pop_front();
          check("frm_len_src", {16'(bus.frm_len_bytes), 16'(bus.frm_src)}, e);
        end
      end
      if (bus.err_len) begin
        check("err_expected", q_err.size() != 0, 1);
        if (q_err.size() != 0) check("err_gnt", bus.gnt, q_err.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int src, input int len, input logic [31:0] b);
    for (int k = 0; k < len; k++) q_data.push_back(b + 32'(k));
    q_frm.push_back({16'(len * 4), 16'(src)});
  endtask

  task automatic req_frame(input int src, input int len, input logic [31:0] b, input bit good);
    len_q[src] = LW'(len);
    base[src]  = b;
    want[src]  = want[src] + 1;
    if (good) push_frame(src, len, b);
    else      q_err.push_back(NR'(1 << src));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (q_data.size() == 0 && q_frm.size() == 0 && q_err.size() == 0 && bus.req == '0) break;
      step(1);
    end
    check({tag, "_drain_data"}, q_data.size(), 0);
    check({tag, "_drain_frm"}, q_frm.size(), 0);
    check({tag, "_drain_err"}, q_err.size(), 0);
    step(2);
  endtask

  task automatic check_zero(input string p);
    check({p, "_gnt"}, bus.gnt, 0);
    check({p, "_req_ready"}, bus.req_ready, 0);
    check({p, "_wr_en"}, bus.fifo_wr_en, 0);
    check({p, "_wr_data"}, bus.fifo_wr_data, 0);
    check({p, "_frm_done"}, bus.frm_done, 0);
    check({p, "_frm_len"}, bus.frm_len_bytes, 0);
    check({p, "_frm_src"}, bus.frm_src, 0);
    check({p, "_err_len"}, bus.err_len, 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int s_wr;
    int s_done;
    bus.fifo_wr_full     = 1'b0;
    bus.fifo_almost_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    step(1);

    // Single frame: requester 0, 4 words A0..A3.
    req_frame(0, 4, 32'hA0, 1'b1);
    step(1);
    check("single_gnt_early", bus.gnt, 0);
    step(1);
    check("single_gnt", bus.gnt, 2'b01);
    check("single_wr0_en", bus.fifo_wr_en, 1);
    check("single_wr0_data", bus.fifo_wr_data, 32'hA0);
    step(3);
    check("single_wr3_en", bus.fifo_wr_en, 1);
    check("single_wr3_data", bus.fifo_wr_data, 32'hA3);
    step(1);
    check("single_done", bus.frm_done, 1);
    check("single_bytes", bus.frm_len_bytes, 16);
    check("single_src", bus.frm_src, 0);
    check("single_gnt_drop", bus.gnt, 0);
    step(1);
    check("single_done_pulse", bus.frm_done, 0);
    wait_drain("single", 20);

    // Almost-full gating on requester 1.
    bus.fifo_almost_full = 1'b1;
    req_frame(1, 2, 32'h50, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("af_no_gnt", bus.gnt, 0);
    end
    bus.fifo_almost_full = 1'b0;
    step(1);
    check("af_gnt_early", bus.gnt, 0);
    step(1);
    check("af_gnt", bus.gnt, 2'b10);
    wait_drain("af", 20);

    // Round-robin: both held, two frames each, expected order 0,1,0,1.
    len_q[0] = LW'(2); base[0] = 32'h100;
    len_q[1] = LW'(2); base[1] = 32'h200;
    want[0] = want[0] + 2;
    want[1] = want[1] + 2;
    push_frame(0, 2, 32'h100);
    push_frame(1, 2, 32'h200);
    push_frame(0, 2, 32'h100);
    push_frame(1, 2, 32'h200);
    wait_drain("rr", 80);

    // Full stall mid-frame; almost_full raised during XFER must not pause it.
    s_wr = wr_total;
    s_done = done_total;
    req_frame(0, 8, 32'hB0, 1'b1);
    step(2);
    check("stall_gnt", bus.gnt, 2'b01);
    bus.fifo_almost_full = 1'b1;
    step(2);
    check("stall_af_wr_en", bus.fifo_wr_en, 1);
    bus.fifo_wr_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_ready", bus.req_ready, 0);
      check("stall_wr_en", bus.fifo_wr_en, 0);
      step(1);
    end
    bus.fifo_wr_full = 1'b0;
    wait_drain("stall", 40);
    check("stall_writes", wr_total - s_wr, 8);
    check("stall_dones", done_total - s_done, 1);
    bus.fifo_almost_full = 1'b0;

    // Bad lengths 0 and 381 on requester 0, then requester 1 served normally.
    for (int t = 0; t < 2; t++) begin
      s_wr = wr_total;
      req_frame(0, (t == 0) ? 0 : 381, 32'h0, 1'b0);
      step(1);
      check("bad_gnt_early", bus.gnt, 0);
      step(1);
      check("bad_gnt", bus.gnt, 2'b01);
      check("bad_err", bus.err_len, 1);
      check("bad_wr_en", bus.fifo_wr_en, 0);
      step(1);
      check("bad_err_pulse", bus.err_len, 0);
      check("bad_gnt_pulse", bus.gnt, 0);
      wait_drain("bad", 10);
      check("bad_no_writes", wr_total - s_wr, 0);
    end
    req_frame(1, 2, 32'h60, 1'b1);
    step(2);
    check("after_bad_gnt", bus.gnt, 2'b10);
    wait_drain("after_bad", 20);

    // Largest legal frame.
    req_frame(1, 380, 32'h1000, 1'b1);
    wait_drain("max", 450);

    // Reset after 3 of 10 words: no descriptor, clean restart.
    s_wr = wr_total;
    s_done = done_total;
    len_q[0] = LW'(10);
    base[0]  = 32'hD0;
    want[0]  = want[0] + 1;
    for (int k = 0; k < 3; k++) q_data.push_back(32'hD0 + 32'(k));
    for (int k = 0; k < 40; k++) begin
      if (wr_total - s_wr >= 3) break;
      step(1);
    end
    check("rst_wr_count", wr_total - s_wr, 3);
    rst = 1'b1;
    want[0] = served[0];
    #1;
    check_zero("midrst");
    step(2);
    rst = 1'b0;
    step(3);
    check("rst_no_done", done_total - s_done, 0);
    check("rst_data_consumed", q_data.size(), 0);
    req_frame(1, 3, 32'hC0, 1'b1);
    step(1);
    check("post_rst_gnt_early", bus.gnt, 0);
    step(1);
    check("post_rst_gnt", bus.gnt, 2'b10);
    wait_drain("post_rst", 20);
    check("post_rst_dones", done_total - s_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
